// File: rtl/hmmm_mem_arbiter.sv
// Arbiter sharing the single-port program/data SRAM between the Hmmm CPU and
// the host loader port: round-robin grant, fixed read latency, one-cycle ack.
module hmmm_mem_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  input  logic                  host_lock,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic                  r_owner;
  logic                  r_last_owner;
  logic                  r_busy;
  logic                  r_cpu_ack;
  logic                  r_host_ack;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_host_rdata;

  logic                  w_host_elig;
  logic                  w_cpu_elig;
  logic                  w_win;
  logic                  w_grant_host;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  assign w_host_elig = host_req;
  assign w_cpu_elig  = cpu_req & ~host_lock;
  assign w_win       = w_host_elig | w_cpu_elig;

  // Grant selection; on a tie the requester that did not go last wins.
  always_comb begin
    w_grant_host = 1'b0;
    if (w_host_elig && w_cpu_elig) begin
      w_grant_host = ~r_last_owner;
    end else if (w_host_elig) begin
      w_grant_host = 1'b1;
    end else begin
      w_grant_host = 1'b0;
    end
  end

  // Winner's request fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_grant_host) begin
      w_sel_we    = host_we;
      w_sel_addr  = host_addr;
      w_sel_wdata = host_wdata;
    end else begin
      w_sel_we    = cpu_we;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
    end
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT x MEM_LATENCY -> ACK.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_busy       <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_cpu_ack  <= 1'b0;
      r_host_ack <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win) begin
            r_owner     <= w_grant_host;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_W'(MEM_LATENCY);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            // mem_rdata is valid in the final WAIT cycle only.
            if (!r_we && r_owner) begin
              r_host_rdata <= mem_rdata;
            end else if (!r_we) begin
              r_cpu_rdata <= mem_rdata;
            end else begin
              r_cpu_rdata <= r_cpu_rdata;
            end
            r_host_ack <= r_owner;
            r_cpu_ack  <= ~r_owner;
            r_state    <= S_ACK;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_ACK: begin
          r_last_owner <= r_owner;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_ack    = r_cpu_ack;
  assign host_rdata = r_host_rdata;
  assign host_ack   = r_host_ack;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign owner      = r_owner;
  assign busy       = r_busy;

endmodule

// File: tb/tb_hmmm_mem_arbiter.sv
// Scoreboard bench for hmmm_mem_arbiter: directed accesses push expected acks,
// monitors pop and compare on every ack (one DUT at latency 1, one at latency 3).
module tb_hmmm_mem_arbiter;

  typedef struct {
    logic        who;
    logic        we;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [7:0]  cpu_addr, host_addr, mem_addr;
  logic [15:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, host_ack, mem_en, mem_we, owner, busy;

  logic        cpu_req3, host_req3;
  logic [7:0]  cpu_addr3, mem_addr3;
  logic [15:0] cpu_rdata3, host_rdata3, mem_wdata3, mem_rdata3;
  logic        cpu_ack3, host_ack3, mem_en3, mem_we3, owner3, busy3;
  logic        garbage3 = 1'b0;

  hmmm_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_lock(host_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  hmmm_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata(16'h0000),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
    .host_req(host_req3), .host_we(1'b0), .host_addr(8'h00), .host_wdata(16'h0000),
    .host_rdata(host_rdata3), .host_ack(host_ack3), .host_lock(1'b0),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .owner(owner3), .busy(busy3)
  );

  // Power-up memory content for addresses never written.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h2A:   init_val = 16'h1234;
      8'h10:   init_val = 16'h1111;
      8'h20:   init_val = 16'h2222;
      8'h30:   init_val = 16'h3333;
      8'h77:   init_val = 16'h5A5A;
      default: init_val = {8'h00, a};
    endcase
  endfunction

  // SRAM model, latency 1
  logic [15:0]  mem [256];
  logic [255:0] wvld = '0;
  logic [15:0]  rd_q = 16'h0000;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]  <= mem_wdata;
      wvld[mem_addr] <= 1'b1;
    end else if (mem_en) begin
      rd_q <= wvld[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end
  end
  assign mem_rdata = rd_q;

  // SRAM model, latency 3 (read-only)
  logic [15:0] p3 [3] = '{16'h0000, 16'h0000, 16'h0000};
  always @(posedge clk) begin
    if (mem_en3 && !mem_we3) p3[0] <= init_val(mem_addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = garbage3 ? 16'hDEAD : p3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no ack within bound (cycle %0d)", name, cyc);
  endtask

  exp_t q[$];
  exp_t q3[$];
  logic [15:0] m_cpu = 16'h0000;
  logic [15:0] m_host = 16'h0000;

  // Monitor for the latency-1 DUT
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      m_cpu  = 16'h0000;
      m_host = 16'h0000;
    end else if (cpu_ack || host_ack) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", {30'd0, cpu_ack, host_ack}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("ack_who", {30'd0, cpu_ack, host_ack}, e.who ? 32'd1 : 32'd2);
        chk("ack_owner", owner, e.who);
        chk("ack_busy", busy, 1'b1);
        if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
        if (!e.we && e.who) m_host = e.data;
        else if (!e.we) m_cpu = e.data;
        chk("cpu_rdata", cpu_rdata, m_cpu);
        chk("host_rdata", host_rdata, m_host);
      end
    end
  end

  // Monitor for the latency-3 DUT
  always @(negedge clk) begin
    exp_t e;
    if (rst && (cpu_ack3 || host_ack3)) begin
      if (q3.size() == 0) begin
        chk("unexpected_ack3", {30'd0, cpu_ack3, host_ack3}, 32'd0);
      end else begin
        e = q3.pop_front();
        chk("ack3_who", {30'd0, cpu_ack3, host_ack3}, 32'd2);
        chk("ack3_cycle", cyc, e.cyc);
        chk("cpu_rdata3", cpu_rdata3, e.data);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, mem_en, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_acks"}, {cpu_ack, host_ack}, 2'b00);
    chk({tag, "_busy_owner"}, {busy, owner}, 2'b00);
    chk({tag, "_mem_addr"}, mem_addr, 8'h00);
    chk({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 16'h0000);
    chk({tag, "_host_rdata"}, host_rdata, 16'h0000);
  endtask

  // One complete handshake from a single requester on the latency-1 DUT.
  task automatic do_access(input logic who, input logic we, input logic [7:0] a,
                           input logic [15:0] d, input logic [15:0] exp_d);
    exp_t x;
    logic got;
    @(negedge clk);
    if (who) begin
      host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    end
    x.who = who; x.we = we; x.data = exp_d; x.cyc = cyc + 3;
    q.push_back(x);
    @(negedge clk);
    chk("issue_en", mem_en, 1'b1);
    chk("issue_we", mem_we, we);
    chk("issue_addr", mem_addr, a);
    if (we) chk("issue_wdata", mem_wdata, d);
    chk("issue_owner", owner, who);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0) chk("wait_en_we", {mem_en, mem_we}, 2'b00);
      got = who ? host_ack : cpu_ack;
    end
    if (!got) timeout("access_ack");
    if (who) host_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  initial begin
    exp_t x;
    int c, n;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 16'h0000;
    host_lock = 1'b0;
    cpu_req3 = 1'b0; host_req3 = 1'b0; cpu_addr3 = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // CPU read, host write + read back
    do_access(1'b0, 1'b0, 8'h2A, 16'h0000, 16'h1234);
    do_access(1'b1, 1'b1, 8'h05, 16'hBEEF, 16'h0000);
    do_access(1'b1, 1'b0, 8'h05, 16'h0000, 16'hBEEF);

    // Both held high: grants alternate CPU, host, CPU, host
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    host_we = 1'b0; host_addr = 8'h20; host_req = 1'b1;
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      x.who = k[0]; x.we = 1'b0; x.data = k[0] ? 16'h2222 : 16'h1111; x.cyc = c + 3 + 4 * k;
      q.push_back(x);
    end
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) n++;
    end
    if (n < 4) timeout("round_robin");
    cpu_req = 1'b0; host_req = 1'b0;

    // host_lock blocks a held CPU request through three host writes
    @(negedge clk);
    host_lock = 1'b1;
    cpu_we = 1'b0; cpu_addr = 8'h30; cpu_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_access(1'b1, 1'b1, 8'h40 + 8'(k), 16'hA0A0 + 16'(k), 16'h0000);
    end
    @(negedge clk);
    chk("lock_idle_busy", busy, 1'b0);
    host_lock = 1'b0;
    x.who = 1'b0; x.we = 1'b0; x.data = 16'h3333; x.cyc = cyc + 3;
    q.push_back(x);
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (cpu_ack) n = 1;
    end
    if (n == 0) timeout("unlock_cpu");
    cpu_req = 1'b0;
    do_access(1'b1, 1'b0, 8'h41, 16'h0000, 16'hA0A1);

    // Latency 3 CPU read, then garbage on mem_rdata after capture
    @(negedge clk);
    cpu_addr3 = 8'h77; cpu_req3 = 1'b1;
    x.who = 1'b0; x.we = 1'b0; x.data = 16'h5A5A; x.cyc = cyc + 5;
    q3.push_back(x);
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (cpu_ack3) n = 1;
    end
    if (n == 0) timeout("lat3_ack");
    cpu_req3 = 1'b0;
    garbage3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat3_rdata_hold", cpu_rdata3, 16'h5A5A);
    chk("lat3_idle", busy3, 1'b0);

    // Reset during WAIT of a host read aborts it without ack
    @(negedge clk);
    host_we = 1'b0; host_addr = 8'h20; host_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wait", busy, 1'b1);
    rst = 1'b0;
    cpu_we = 1'b0; cpu_addr = 8'h2A; cpu_req = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst = 1'b1;
    c = cyc;
    x.who = 1'b0; x.we = 1'b0; x.data = 16'h1234; x.cyc = c + 3;
    q.push_back(x);
    x.who = 1'b1; x.we = 1'b0; x.data = 16'h2222; x.cyc = c + 7;
    q.push_back(x);
    for (int i = 0; i < 40 && (cpu_req || host_req); i++) begin
      @(negedge clk);
      if (cpu_ack) cpu_req = 1'b0;
      if (host_ack) host_req = 1'b0;
    end
    if (cpu_req || host_req) timeout("post_reset");

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    chk("queue3_drained", q3.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/hmmm_mem_arbiter.md
Name: hmmm_mem_arbiter

Overview:
Shares the single-port program/data SRAM between the Hmmm CPU core (MAR/MDR path) and the host loader/debug port. It arbitrates between the two requesters, sequences each access with a fixed memory read latency, and returns read data with a one-cycle ack. The host can lock out the CPU for program load. It sits between the control/datapath memory interface and the SRAM macro.

Parameters:
ADDR_WIDTH, 8, memory word address width (256 words).
DATA_WIDTH, 16, memory word width.
MEM_LATENCY, 1, cycles from mem_en asserted to mem_rdata valid; must be at least 1.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous, active-low reset.
cpu_req  in  1  CPU access request (level).
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
cpu_addr  in  ADDR_WIDTH  CPU address; stable while cpu_req is high.
cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req is high.
cpu_rdata  out  DATA_WIDTH  registered CPU read data.
cpu_ack  out  1  one-cycle completion pulse.
host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  host request, same rules as CPU.
host_rdata  out  DATA_WIDTH  registered host read data.
host_ack  out  1  one-cycle completion pulse.
host_lock  in  1  while high, CPU requests are ineligible.
mem_en  out  1  SRAM access strobe, one cycle per access.
mem_we  out  1  SRAM write enable; 0 whenever mem_en is 0.
mem_addr  out  ADDR_WIDTH  registered SRAM address.
mem_wdata  out  DATA_WIDTH  registered SRAM write data.
mem_rdata  in  DATA_WIDTH  SRAM read data.
owner  out  1  0 = CPU, 1 = host; valid while busy.
busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (rst low at a clock edge): state = IDLE. mem_en, mem_we, cpu_ack, host_ack, busy and owner are 0. cpu_rdata, host_rdata, mem_addr and mem_wdata are 0. last_owner = host.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: evaluates eligible requests each cycle. Host is eligible when host_req is high. CPU is eligible when cpu_req is high and host_lock is low.
  - Exactly one eligible: that requester wins.
  - Both eligible: the requester that is not last_owner wins (round-robin).
  - On a win: latch owner, we, addr and wdata from the winner, then go to ISSUE.
- ISSUE (1 cycle): mem_en = 1, mem_we = latched we, mem_addr and mem_wdata driven from the latched values. Next state is WAIT with counter = MEM_LATENCY.
- WAIT (MEM_LATENCY cycles): counter decrements each cycle. In the last WAIT cycle, mem_rdata is valid.
  - Read: capture mem_rdata at that edge into the owner's rdata register only.
  - Write: neither rdata register changes.
  - Next state is ACK.
- ACK (1 cycle): the owner's ack is high and the other ack stays 0. Set last_owner = owner, then go to IDLE.
- Timing: with the request sampled in cycle 0, ISSUE is cycle 1 and ack is high in cycle MEM_LATENCY+2. Reads and writes have identical timing. Peak throughput is one access per MEM_LATENCY+3 cycles.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees ack.
  - The cycle after ack is IDLE; req still high there is treated as a new request.
  - Dropping req before ack is illegal; the access completes and acks regardless.
- Requests are not evaluated outside IDLE. A requester arriving mid-access waits for the next IDLE.
- host_lock rising mid-access does not abort a CPU access already granted; it only blocks new CPU grants.
- mem_addr and mem_wdata hold their last values between accesses. mem_we is forced to 0 outside ISSUE.
- cpu_rdata and host_rdata hold their values until the next read completes for that requester.
- Reset mid-access: the access is aborted and no ack is issued. A write whose ISSUE cycle already occurred may have modified memory.

Test Plan:
- CPU-only read, MEM_LATENCY=1, addr 0x2A, mem model returns 0x1234 → mem_en high in cycle 1, cpu_ack high in cycle 3, cpu_rdata=0x1234, host_ack stays 0.
- Host write addr 0x05 data 0xBEEF, then host read 0x05 → first host_ack in cycle 3; second access mem_en with mem_we=0, host_rdata=0xBEEF; cpu_rdata unchanged at 0.
- Both requesters held high from reset for 4 accesses → grants alternate CPU, host, CPU, host; owner matches each ack.
- host_lock=1 with cpu_req held high, host issues 3 writes → no cpu_ack; after host_lock drops, the CPU is granted at the next IDLE.
- MEM_LATENCY=3, CPU read → cpu_ack high in cycle 5; mem_rdata changed to garbage after the capture edge does not alter cpu_rdata.
- rst low during WAIT of a host read → no host_ack, all outputs at reset values next cycle; a request held high after rst releases is served normally with CPU-first tie-break.
